// File: rtl/signed_seg_scan_driver.sv
// Signed value to multiplexed seven-segment display driver.
// Converts a two's-complement value to BCD (shift-add-3, one bit
// per clock), places a minus glyph, and scans DIGITS digits.
// Ports: clk, rst_n (sync, active-low), value/load (capture
// request), busy, overflow, seg {g..a} and an (both active-low).
// Optional macro SEG_ZERO_BLANK_EN: leading-zero blanking with the
// minus glyph placed next to the most-significant non-zero digit.
module signed_seg_scan_driver #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1);
    localparam logic [63:0] LIM_POS = pow10(DIGITS);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int BW = 4 * DIGITS;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t          state, state_nx;
    logic            neg, ovf_pend;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]   bcd, bcd_adj;
    logic [CW-1:0]   cnt;
    logic [6:0]      glyph    [DIGITS];
    logic [6:0]      glyph_nx [DIGITS];
    logic [DW-1:0]   div;
    logic [IW-1:0]   idx;

    logic            in_neg, in_ovf;
    logic [WIDTH-1:0] in_mag;

    // Magnitude is WIDTH bits unsigned, so the most-negative input
    // maps to 2^(WIDTH-1) without loss.
    always_comb begin
        in_neg = value[WIDTH-1];
        in_mag = in_neg ? (~value + 1'b1) : value;
        in_ovf = in_neg ? (64'(in_mag) >= LIM_NEG)
                        : (64'(in_mag) >= LIM_POS);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (load) state_nx = in_ovf ? COMMIT : CONVERT;
            CONVERT: if (cnt == CW'(WIDTH - 1)) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        logic [3:0] nib;
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd[4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    always_comb begin
        int msd;
        msd = 0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd0) msd = i;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef SEG_ZERO_BLANK_EN
            if (i <= msd)
                glyph_nx[i] = seg_code(bcd[4*i +: 4]);
            else if (neg && i == msd + 1)
                glyph_nx[i] = MINUS;
            else
                glyph_nx[i] = BLANK;
`else
            if (neg && i == DIGITS - 1)
                glyph_nx[i] = MINUS;
            else
                glyph_nx[i] = seg_code(bcd[4*i +: 4]);
`endif
            if (ovf_pend) glyph_nx[i] = MINUS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            neg      <= 1'b0;
            ovf_pend <= 1'b0;
            mag      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DIGITS; i++) glyph[i] <= BLANK;
        end else begin
            unique case (state)
                IDLE: if (load) begin
                    neg      <= in_neg;
                    mag      <= in_mag;
                    ovf_pend <= in_ovf;
                    bcd      <= '0;
                    cnt      <= '0;
                end
                CONVERT: begin
                    bcd <= (bcd_adj << 1) | BW'(mag[WIDTH-1]);
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                COMMIT: begin
                    glyph    <= glyph_nx;
                    overflow <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
            seg <= BLANK;
            an  <= '1;
        end else begin
            if (div == DW'(REFRESH_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= glyph[idx];
        end
    end

endmodule
